rr_encoder42: RTL and testbench

Registered 4-to-2 round-robin encoder: the encoding counterpart of the team's 2-to-4 one-hot decoder. It samples a 4-bit request vector, selects one asserted line in rotating priority order, and presents its 2-bit index on a valid/ready handshake. It also flags and counts multi-hot samples. It sits in front of the 4:1 select paths, turning one-hot/multi-hot request lines back into a binary select.

---
 rtl/rr_encoder42_pkg.sv | 11 +
 rtl/rr_encoder42_if.sv | 25 ++
 rtl/rr_encoder42_pick4.sv | 33 +++
 rtl/rr_encoder42.sv | 86 ++++++++
 tb/tb_rr_encoder42.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/rr_encoder42_pkg.sv
// Shared widths and FSM state type for the 4-to-2 round-robin encoder.
// The generic name is kept because the picker and interface import it too.
package enc_pkg;
    localparam int REQ_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/rr_encoder42_if.sv
// Request/grant bundle between the request sources/consumer and the encoder.
// The encoder connects through the slave modport.
interface rr_encoder42_if
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             en;
    logic [REQ_W-1:0] req;
    logic             ready_i;
    logic [IDX_W-1:0] idx_o;
    logic             valid_o;
    logic             multi_o;
    logic [CNT_W-1:0] cnt_o;

    modport master (
        output en, req, ready_i,
        input  idx_o, valid_o, multi_o, cnt_o
    );

    modport slave (
        input  en, req, ready_i,
        output idx_o, valid_o, multi_o, cnt_o
    );
endinterface

// File: rtl/rr_encoder42_pick4.sv
// Combinational rotating-priority picker: first set request at or after base.
module rr_pick4
    import enc_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);
    logic [REQ_W-1:0] w_rot;
    logic [IDX_W-1:0] w_pos [REQ_W];

    // w_rot[k] is the request that sits k slots after base (2-bit wrap).
    generate
        for (genvar gi = 0; gi < REQ_W; gi++) begin : g_rot
            assign w_pos[gi] = base + IDX_W'(gi);
            assign w_rot[gi] = req[w_pos[gi]];
        end
    endgenerate

    always_comb begin
        idx = base;
        for (int k = REQ_W - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                idx = w_pos[k];
            end
        end
    end

    assign any   = |req;
    assign multi = ($countones(req) > 1);
endmodule

// File: rtl/rr_encoder42.sv
// Registered 4-to-2 round-robin encoder with valid/ready output and a
// saturating count of multi-hot loads.
module rr_encoder42
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    rr_encoder42_if.slave bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic             r_multi;
    logic [CNT_W-1:0] r_cnt;

    logic             w_valid;
    logic             w_accept;
    logic             w_load;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_any;
    logic             w_sel_multi;

    assign w_accept = w_valid && bus.ready_i;
    // On an accept edge the rotation continues from the grant being retired,
    // so back-to-back loads do not wait for r_ptr to update.
    assign w_base   = w_accept ? (r_idx + 1'b1) : r_ptr;
    assign w_load   = bus.en && w_sel_any && ((r_state == IDLE) || w_accept);

    rr_pick4 u_pick (
        .req   (bus.req),
        .base  (w_base),
        .idx   (w_sel_idx),
        .any   (w_sel_any),
        .multi (w_sel_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = HOLD;
        end else if (w_accept) begin
            w_state_next = IDLE;
        end
    end

    always_comb begin
        w_valid = (r_state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_ptr   <= '0;
            r_multi <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= r_idx + 1'b1;
            end
            if (w_load) begin
                r_idx   <= w_sel_idx;
                r_multi <= w_sel_multi;
                if (w_sel_multi && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.idx_o   = r_idx;
    assign bus.valid_o = w_valid;
    assign bus.multi_o = r_multi;
    assign bus.cnt_o   = r_cnt;
endmodule

// File: tb/tb_rr_encoder42.sv
// Directed bench for rr_encoder42: a vector table for the main sequence plus
// hand sequences for async reset, round-robin from reset and counter saturation.
module tb_rr_encoder42;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_encoder42_if #(.CNT_W(8)) bus8 ();
    rr_encoder42_if #(.CNT_W(2)) bus2 ();

    rr_encoder42 #(.CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    rr_encoder42 #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       rdy;
        logic       ev;
        logic [1:0] eidx;
        logic       em;
        int         ecnt;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 0};
        tbl[3]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 1};
        tbl[4]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 2};
        tbl[5]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 3};
        tbl[6]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4};
        tbl[7]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 5};
        tbl[8]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 6};
        tbl[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 6};
        tbl[10] = '{1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 6};
        tbl[11] = '{1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 6};
        tbl[12] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd1, 1'b0, 6};
        tbl[13] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd1, 1'b0, 6};
        tbl[14] = '{1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 6};
        tbl[15] = '{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 6};
        tbl[16] = '{1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 6};
        tbl[17] = '{1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 6};
        tbl[18] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 6};
        tbl[19] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 6};
        tbl[20] = '{1'b1, 4'b1100, 1'b1, 1'b1, 2'd2, 1'b1, 7};
        tbl[21] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 7};

        rst_n        = 1'b0;
        bus8.en      = 1'b0;
        bus8.req     = 4'b0000;
        bus8.ready_i = 1'b0;
        bus2.en      = 1'b0;
        bus2.req     = 4'b0000;
        bus2.ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", int'(bus8.valid_o), 0);
        check("reset idx",   int'(bus8.idx_o),   0);
        check("reset multi", int'(bus8.multi_o), 0);
        check("reset cnt",   int'(bus8.cnt_o),   0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            bus8.en      = tbl[i].en;
            bus8.req     = tbl[i].req;
            bus8.ready_i = tbl[i].rdy;
            step();
            $display("vec %0d: en=%0b req=%4b rdy=%0b -> valid=%0b idx=%0d multi=%0b cnt=%0d",
                     i, tbl[i].en, tbl[i].req, tbl[i].rdy,
                     bus8.valid_o, bus8.idx_o, bus8.multi_o, bus8.cnt_o);
            check($sformatf("vec%0d valid", i), int'(bus8.valid_o), int'(tbl[i].ev));
            check($sformatf("vec%0d idx", i),   int'(bus8.idx_o),   int'(tbl[i].eidx));
            check($sformatf("vec%0d multi", i), int'(bus8.multi_o), int'(tbl[i].em));
            check($sformatf("vec%0d cnt", i),   int'(bus8.cnt_o),   tbl[i].ecnt);
        end

        // Enter HOLD, then pull reset between clock edges.
        bus8.en      = 1'b1;
        bus8.req     = 4'b1111;
        bus8.ready_i = 1'b0;
        step();
        check("pre-reset valid", int'(bus8.valid_o), 1);
        check("pre-reset cnt",   int'(bus8.cnt_o),   8);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset valid", int'(bus8.valid_o), 0);
        check("async reset idx",   int'(bus8.idx_o),   0);
        check("async reset multi", int'(bus8.multi_o), 0);
        check("async reset cnt",   int'(bus8.cnt_o),   0);
        bus8.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-reset idle 1", int'(bus8.valid_o), 0);
        step();
        check("post-reset idle 2", int'(bus8.valid_o), 0);

        // Round-robin from reset: pointer starts at 0.
        bus8.req     = 4'b1111;
        bus8.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("rr %0d: valid=%0b idx=%0d multi=%0b cnt=%0d",
                     i, bus8.valid_o, bus8.idx_o, bus8.multi_o, bus8.cnt_o);
            check($sformatf("rr%0d valid", i), int'(bus8.valid_o), 1);
            check($sformatf("rr%0d idx", i),   int'(bus8.idx_o),   i % 4);
            check($sformatf("rr%0d multi", i), int'(bus8.multi_o), 1);
            check($sformatf("rr%0d cnt", i),   int'(bus8.cnt_o),   i + 1);
        end
        bus8.req = 4'b0000;

        // Saturation on the 2-bit counter instance.
        bus2.en      = 1'b1;
        bus2.req     = 4'b0011;
        bus2.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("sat %0d: valid=%0b idx=%0d multi=%0b cnt=%0d",
                     i, bus2.valid_o, bus2.idx_o, bus2.multi_o, bus2.cnt_o);
            check($sformatf("sat%0d valid", i), int'(bus2.valid_o), 1);
            check($sformatf("sat%0d idx", i),   int'(bus2.idx_o),   i % 2);
            check($sformatf("sat%0d cnt", i),   int'(bus2.cnt_o),   (i < 3) ? i + 1 : 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
